cs_window: RTL
==============

CS_WINDOW -- requirements
Module: cs_window

Interface
REQ-001 Parameter DW, default 8: sample width in bits (unsigned).
REQ-002 Parameter DEPTH, default 9: window length in samples; legal range 2..64.
REQ-003 Parameter SHIFT, default 3: right-shift applied to the result.
REQ-004 Parameter YW, default 10: output width in bits.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 X  input  DW  sample, qualified by in_valid.
REQ-008 in_valid  input  1  X accepted on a rising edge where in_valid=1; no backpressure.
REQ-009 mode  input  1  0 = approximation mode, 1 = plain-sum mode; sampled together with X.
REQ-010 Y  output  YW  registered result.
REQ-011 out_valid  output  1  one-cycle pulse marking Y valid.

Function
REQ-012 The window shall shift only on accepted samples: newest X enters, oldest sample leaves; without in_valid the window, sum and count hold.
REQ-013 The running sum S shall be updated incrementally (S + X - oldest) at full width DW+ceil(log2(DEPTH)), with no overflow.
REQ-014 The fill counter shall count accepted samples and saturate at DEPTH.
REQ-015 Stage 1 (edge t, sample accepted) shall register the new window, the new S and mode.
REQ-016 Stage 2 (edge t+1) shall compute from the stage-1 registers and register Y; out_valid shall be 1 for exactly the cycle after edge t+1, and only if the count was DEPTH after edge t.
REQ-017 Latency shall be fixed at 2 edges from acceptance to Y/out_valid; back-to-back samples shall produce back-to-back pulses.
REQ-018 Approx value A shall be the largest window sample x with DEPTH*x <= S, i.e. x <= floor(S/DEPTH); no divider.
REQ-019 A always exists because the window minimum satisfies the condition; equal candidates are indistinguishable, so no tie rule is needed.
REQ-020 Mode 0 shall give R = (S + DEPTH*A) >> SHIFT.
REQ-021 Mode 1 shall give R = S >> SHIFT.
REQ-022 R shall be computed at full width; if R > 2^YW-1, Y shall saturate to 2^YW-1.
REQ-023 Y shall hold its last value when out_valid=0.
REQ-024 A mode change shall affect only samples accepted with the new mode value; in-flight results shall keep their captured mode.

Reset
REQ-025 reset=1 at a rising edge shall clear the window to 0, S to 0, the count to 0, the stage-1 registers, Y to 0 and out_valid to 0.
REQ-026 reset shall take priority over in_valid in the same cycle; that sample shall be dropped.
REQ-027 A reset mid-fill or mid-stream shall discard the window and pipeline contents, and DEPTH new samples shall be needed before the next out_valid.

Verification
REQ-028 Defaults, mode 0, samples 10,20,...,90 → no out_valid for the first 8; after the 9th, S=450, A=50, Y=112, out_valid=1 for one cycle.
REQ-029 Continue with 100 → window 20..100, S=540, A=60, Y=135; then X=100 in mode 1 → window 30..100,100, S=620, Y=77.
REQ-030 Defaults, samples 0 (x8) then 100 → S=100, A=0, Y=12; samples 1..9 → S=45, A=5, Y=11.
REQ-031 DW=8, YW=8, all samples 255 → R=573 saturates to Y=255.
REQ-032 5 samples, then reset, then 8 samples → no out_valid; 9th sample → out_valid 2 edges later; in_valid gaps between samples shall not alter results.

Source files
------------

// File: rtl/cs_window.sv
// rtl/cs_window.sv - sliding-window sum with "largest sample not above mean" approximation
// Two-stage pipeline: stage 1 holds window/sum/mode, stage 2 registers saturated Y.
module cs_window #(
  parameter int DW    = 8,
  parameter int DEPTH = 9,
  parameter int SHIFT = 3,
  parameter int YW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] X,
  input  logic          in_valid,
  input  logic          mode,
  output logic [YW-1:0] Y,
  output logic          out_valid
);

  localparam int SW = DW + $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = SW + 1;

  logic [DW-1:0] r_win [DEPTH];
  logic [SW-1:0] r_sum;
  logic [CW-1:0] r_cnt;
  logic          r_s1_valid;
  logic          r_s1_mode;
  logic [YW-1:0] r_y;
  logic          r_out_valid;

  logic [CW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_a;
  logic [RW-1:0] w_r;
  logic [RW-1:0] w_rs;
  logic [YW-1:0] w_y;

  assign w_cnt_nxt = (r_cnt == CW'(DEPTH)) ? r_cnt : r_cnt + CW'(1);

  // DEPTH*x <= S is the divider-free form of x <= floor(S/DEPTH)
  always_comb begin
    w_a = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((RW'(r_win[i]) * RW'(DEPTH)) <= RW'(r_sum) && r_win[i] > w_a)
        w_a = r_win[i];
    end
    w_r  = r_s1_mode ? RW'(r_sum) : RW'(r_sum) + RW'(w_a) * RW'(DEPTH);
    w_rs = w_r >> SHIFT;
    if ((w_rs >> YW) != '0)
      w_y = {YW{1'b1}};
    else
      w_y = YW'(w_rs);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        for (int i = DEPTH - 1; i > 0; i--) r_win[i] <= r_win[i-1];
        r_win[0]   <= X;
        // unfilled slots are zero, so subtracting the oldest is always exact
        r_sum      <= r_sum + SW'(X) - SW'(r_win[DEPTH-1]);
        r_cnt      <= w_cnt_nxt;
        r_s1_mode  <= mode;
        r_s1_valid <= (w_cnt_nxt == CW'(DEPTH));
      end else begin
        r_s1_valid <= 1'b0;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) r_y <= w_y;
    end
  end

  assign Y         = r_y;
  assign out_valid = r_out_valid;

endmodule
